spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sync.sv | 23 ++
 rtl/spi_slave.sv | 134 +++++++++++++
 tb/tb_spi_slave.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared defaults and helpers for the SPI mode-0 slave (spi_slave, spi_sync).
package spi_pkg;

    localparam int unsigned SPI_DATA_W      = 16;
    localparam int unsigned SPI_SYNC_STAGES = 2;

    function automatic int unsigned spi_cnt_w(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned SPI_CNT_W = spi_cnt_w(SPI_DATA_W);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, async active-low reset to 0.
module spi_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, fully in the clk_100 domain. Define SPI_SOMI_TRISTATE_EN to
// float SPISOMI while deselected or in reset; otherwise it is driven low.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk_100,
    input  logic              RSTn,
    input  logic              SCK,
    input  logic              SPISIMO,
    output logic              SPISOMI,
    input  logic              SPISTE,
    output logic              rxd_flag,
    output logic [DATA_W-1:0] rxd_data,
    input  logic [DATA_W-1:0] txd_data
);

    localparam int unsigned CNT_W = (DATA_W == SPI_DATA_W) ? SPI_CNT_W : spi_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sck_s, mosi_s, ste_s;
    logic sck_prev_q, ste_prev_q;
    logic sck_rise, sck_fall, ste_fall;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] rx_q,    rx_d;
    logic [DATA_W-1:0] tx_q,    tx_d;
    logic [DATA_W-1:0] rxd_q,   rxd_d;
    logic              flag_q,  flag_d;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_i (clk_100),
        .rst_ni(RSTn),
        .d_i   (SCK),
        .q_o   (sck_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i (clk_100),
        .rst_ni(RSTn),
        .d_i   (SPISIMO),
        .q_o   (mosi_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ste (
        .clk_i (clk_100),
        .rst_ni(RSTn),
        .d_i   (SPISTE),
        .q_o   (ste_s)
    );

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign ste_fall = ~ste_s & ste_prev_q;

    // A frame only opens on a seen SPISTE falling edge, so a select held low
    // across reset release does not start counting SCK edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        rxd_d   = rxd_q;
        flag_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ste_fall) begin
                    state_d = ST_ACTIVE;
                    tx_d    = txd_data;
                end
            end
            ST_ACTIVE: begin
                if (ste_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sck_rise) begin
                    rx_d = {rx_q[DATA_W-2:0], mosi_s};
                    if (cnt_q == LAST_BIT) begin
                        cnt_d  = '0;
                        rxd_d  = {rx_q[DATA_W-2:0], mosi_s};
                        flag_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sck_fall) begin
                    // Counter at zero on a falling edge means a word just completed.
                    if (cnt_q == '0) begin
                        tx_d = txd_data;
                    end else begin
                        tx_d = {tx_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge RSTn) begin
        if (!RSTn) begin
            sck_prev_q <= 1'b0;
            ste_prev_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            rxd_q      <= '0;
            flag_q     <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            ste_prev_q <= ste_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            rxd_q      <= rxd_d;
            flag_q     <= flag_d;
        end
    end

    assign rxd_data = rxd_q;
    assign rxd_flag = flag_q;

`ifdef SPI_SOMI_TRISTATE_EN
    assign SPISOMI = (RSTn && !ste_s) ? tx_q[DATA_W-1] : 1'bz;
`else
    assign SPISOMI = ~ste_s & tx_q[DATA_W-1];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single frames plus back-to-back,
// abort, mid-frame reset and deselected-noise sequences.
module tb_spi_slave;

    logic        clk_100  = 1'b0;
    logic        RSTn     = 1'b0;
    logic        SCK      = 1'b0;
    logic        SPISIMO  = 1'b0;
    logic        SPISTE   = 1'b1;
    wire         SPISOMI;
    logic        rxd_flag;
    logic [15:0] rxd_data;
    logic [15:0] txd_data = 16'h0000;

    int unsigned errors   = 0;
    int unsigned checks   = 0;
    int unsigned flag_cnt = 0;

`ifdef SPI_SOMI_TRISTATE_EN
    logic somi_idle_exp = 1'bz;
`else
    logic somi_idle_exp = 1'b0;
`endif

    typedef struct {
        logic [15:0] mosi;
        logic [15:0] txd;
        logic [15:0] exp_rx;
        logic [15:0] exp_miso;
    } vec_t;

    vec_t vecs[5];

    spi_slave #(
        .DATA_W     (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk_100 (clk_100),
        .RSTn    (RSTn),
        .SCK     (SCK),
        .SPISIMO (SPISIMO),
        .SPISOMI (SPISOMI),
        .SPISTE  (SPISTE),
        .rxd_flag(rxd_flag),
        .rxd_data(rxd_data),
        .txd_data(txd_data)
    );

    always #5 clk_100 = ~clk_100;

    // Counts flag-high cycles, so a stretched pulse shows up as extra flags.
    always @(negedge clk_100) begin
        if (rxd_flag === 1'b1) flag_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Mode 0 master: MOSI set while SCK low, MISO sampled on SCK rising; 5 MHz.
    task automatic send_bits(input logic [15:0] word, input int n, output logic [15:0] miso);
        miso = '0;
        for (int i = 0; i < n; i++) begin
            SPISIMO = word[15-i];
            #100;
            SCK  = 1'b1;
            miso = {miso[14:0], SPISOMI};
            #100;
            SCK  = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] word, output logic [15:0] miso);
        SPISTE = 1'b0;
        #100;
        send_bits(word, 16, miso);
        #100;
        SPISTE = 1'b1;
        #200;
    endtask

    initial begin
        logic [15:0] m, m2;
        int unsigned f0;

        vecs[0] = '{mosi: 16'h4A5B, txd: 16'hC3A1, exp_rx: 16'h4A5B, exp_miso: 16'hC3A1};
        vecs[1] = '{mosi: 16'h0000, txd: 16'hFFFF, exp_rx: 16'h0000, exp_miso: 16'hFFFF};
        vecs[2] = '{mosi: 16'hFFFF, txd: 16'h0000, exp_rx: 16'hFFFF, exp_miso: 16'h0000};
        vecs[3] = '{mosi: 16'h8001, txd: 16'h7FFE, exp_rx: 16'h8001, exp_miso: 16'h7FFE};
        vecs[4] = '{mosi: 16'hA5A5, txd: 16'h5A5A, exp_rx: 16'hA5A5, exp_miso: 16'h5A5A};

        // Reset state
        #52;
        chk("rst_rxd_data", 32'(rxd_data), 32'h0);
        chk("rst_rxd_flag", 32'(rxd_flag), 32'h0);
        chk("rst_somi", {31'b0, SPISOMI}, {31'b0, somi_idle_exp});
        #51;
        RSTn = 1'b1;
        #97;
        chk("idle_somi", {31'b0, SPISOMI}, {31'b0, somi_idle_exp});

        // Single frames
        for (int v = 0; v < 5; v++) begin
            txd_data = vecs[v].txd;
            f0 = flag_cnt;
            frame(vecs[v].mosi, m);
            chk($sformatf("vec%0d_rxd_data", v), 32'(rxd_data), 32'(vecs[v].exp_rx));
            chk($sformatf("vec%0d_miso", v), 32'(m), 32'(vecs[v].exp_miso));
            chk($sformatf("vec%0d_flags", v), flag_cnt - f0, 32'd1);
            chk($sformatf("vec%0d_somi_idle", v), {31'b0, SPISOMI}, {31'b0, somi_idle_exp});
        end

        // Back-to-back words; txd_data changed between first flag and reload
        txd_data = 16'hABCD;
        f0 = flag_cnt;
        SPISTE = 1'b0;
        #100;
        send_bits(16'h0001, 15, m);
        SPISIMO = 1'b1;
        #100;
        SCK = 1'b1;
        m = {m[14:0], SPISOMI};
        #60;
        chk("b2b_first_flags", flag_cnt - f0, 32'd1);
        chk("b2b_first_rxd_data", 32'(rxd_data), 32'h0001);
        txd_data = 16'h1234;
        #40;
        SCK = 1'b0;
        send_bits(16'hFFFF, 16, m2);
        #100;
        SPISTE = 1'b1;
        #200;
        chk("b2b_first_miso", 32'(m), 32'hABCD);
        chk("b2b_second_miso", 32'(m2), 32'h1234);
        chk("b2b_flags", flag_cnt - f0, 32'd2);
        chk("b2b_second_rxd_data", 32'(rxd_data), 32'hFFFF);

        // Abort after 9 bits
        txd_data = 16'hC3A1;
        frame(16'h4A5B, m);
        txd_data = 16'h0F0F;
        f0 = flag_cnt;
        SPISTE = 1'b0;
        #100;
        send_bits(16'hAAAA, 9, m);
        #100;
        SPISTE = 1'b1;
        #200;
        chk("abort_flags", flag_cnt - f0, 32'd0);
        chk("abort_rxd_data", 32'(rxd_data), 32'h4A5B);
        f0 = flag_cnt;
        frame(16'h5555, m);
        chk("post_abort_flags", flag_cnt - f0, 32'd1);
        chk("post_abort_rxd_data", 32'(rxd_data), 32'h5555);
        chk("post_abort_miso", 32'(m), 32'h0F0F);

        // Reset mid-frame, select held low across release
        txd_data = 16'hFEDC;
        SPISTE = 1'b0;
        #100;
        send_bits(16'hFF00, 8, m);
        #50;
        RSTn = 1'b0;
        #1;
        chk("midrst_rxd_data", 32'(rxd_data), 32'h0);
        chk("midrst_rxd_flag", 32'(rxd_flag), 32'h0);
        chk("midrst_somi", {31'b0, SPISOMI}, {31'b0, somi_idle_exp});
        #102;
        RSTn = 1'b1;
        f0 = flag_cnt;
        send_bits(16'hFFFF, 16, m);
        #100;
        chk("held_sel_flags", flag_cnt - f0, 32'd0);
        chk("held_sel_rxd_data", 32'(rxd_data), 32'h0);
        SPISTE = 1'b1;
        #200;
        txd_data = 16'h3C3C;
        f0 = flag_cnt;
        frame(16'h8001, m);
        chk("post_rst_flags", flag_cnt - f0, 32'd1);
        chk("post_rst_rxd_data", 32'(rxd_data), 32'h8001);
        chk("post_rst_miso", 32'(m), 32'h3C3C);

        // SCK noise while deselected
        f0 = flag_cnt;
        for (int i = 0; i < 20; i++) begin
            SPISIMO = i[0];
            SCK = 1'b1;
            #100;
            SCK = 1'b0;
            #100;
        end
        chk("noise_flags", flag_cnt - f0, 32'd0);
        chk("noise_somi", {31'b0, SPISOMI}, {31'b0, somi_idle_exp});
        chk("noise_rxd_data", 32'(rxd_data), 32'h8001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
